tri_dispatch: RTL and testbench

TRI_DISPATCH -- requirements
Module: tri_dispatch

---
 rtl/tri_dispatch_pkg.sv | 31 +++
 rtl/rr_arb2.sv | 37 +++
 rtl/tri_dispatch.sv | 155 +++++++++++++++
 tb/tb_tri_dispatch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_dispatch_pkg.sv
// Shared definitions for the triangle dispatcher: coordinate width,
// requester count, packed-vertex field offsets and the FSM state type.
package tri_dispatch_pkg;

    localparam int COORD_W = 3;
    localparam int N_REQ   = 2;
    localparam int TRI_W   = 6 * COORD_W;

    // Packed triangle layout: {y2,x2,y1,x1,y0,x0}, x0 in the LSBs
    localparam int unsigned X0_OFF = 0 * COORD_W;
    localparam int unsigned Y0_OFF = 1 * COORD_W;
    localparam int unsigned X1_OFF = 2 * COORD_W;
    localparam int unsigned Y1_OFF = 3 * COORD_W;
    localparam int unsigned X2_OFF = 4 * COORD_W;
    localparam int unsigned Y2_OFF = 5 * COORD_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD0,
        LOAD1,
        LOAD2,
        WAIT,
        RUN
    } state_t;

    function automatic logic [COORD_W-1:0] tri_field(input logic [TRI_W-1:0] t,
                                                     input int unsigned off);
        return t[off +: COORD_W];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req        : request vector
//   en         : commit the current grant and rotate priority
//   gnt        : one-hot combinational grant (zero when no request)
module rr_arb2
    import tri_dispatch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [N_REQ-1:0] gnt
);

    // Index of the requester holding priority on a tie
    logic prio;

    always_comb begin
        gnt = '0;
        if (req == 2'b11) begin
            gnt = prio ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    // Whoever wins drops to low priority for the next tie
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (en && (|req)) begin
            prio <= gnt[0];
        end
    end

endmodule

// File: rtl/tri_dispatch.sv
// Triangle dispatcher: arbitrates two requesters, streams the granted
// triangle's three vertices to a rasterizer, forwards its pixels tagged
// with the owner, and signals completion or start timeout.
//   req_valid/req_tri0/req_tri1/req_ready : requester side
//   rast_nt/rast_xi/rast_yi               : vertex load to rasterizer
//   rast_busy/rast_po/rast_xo/rast_yo     : rasterizer status and pixels
//   pix_valid/pix_x/pix_y/pix_id          : forwarded pixels (1-cycle latency)
//   done/done_id                          : completion pulse and owner
//   err                                   : sticky start-timeout flag
//   busy                                  : any state other than IDLE
module tri_dispatch
    import tri_dispatch_pkg::*;
#(
    parameter int START_TMO = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [TRI_W-1:0]   req_tri0,
    input  logic [TRI_W-1:0]   req_tri1,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rast_nt,
    output logic [COORD_W-1:0] rast_xi,
    output logic [COORD_W-1:0] rast_yi,
    input  logic               rast_busy,
    input  logic               rast_po,
    input  logic [COORD_W-1:0] rast_xo,
    input  logic [COORD_W-1:0] rast_yo,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_id,
    output logic               done,
    output logic               done_id,
    output logic               err,
    output logic               busy
);

    localparam int TMO_W = $clog2(START_TMO + 1);

    state_t             state, state_nxt;
    logic [TRI_W-1:0]   hold;
    logic               owner;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [N_REQ-1:0]   gnt;
    logic               grant_en;
    logic               finish;
    logic               tmo_fire;
    logic               pix_take;

    // Arbitration only happens in IDLE; suppressed during reset so
    // req_ready stays low while reset is applied.
    assign grant_en = (state == IDLE) && !reset;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .en    (grant_en),
        .gnt   (gnt)
    );

    assign busy     = (state != IDLE);
    assign pix_take = rast_po && ((state == RUN) || (state == WAIT));

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rast_nt   = 1'b0;
        rast_xi   = '0;
        rast_yi   = '0;
        finish    = 1'b0;
        tmo_fire  = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_en && (|req_valid)) begin
                    req_ready = gnt;
                    state_nxt = LOAD0;
                end
            end
            LOAD0: begin
                rast_nt   = 1'b1;
                rast_xi   = tri_field(hold, X0_OFF);
                rast_yi   = tri_field(hold, Y0_OFF);
                state_nxt = LOAD1;
            end
            LOAD1: begin
                rast_xi   = tri_field(hold, X1_OFF);
                rast_yi   = tri_field(hold, Y1_OFF);
                state_nxt = LOAD2;
            end
            LOAD2: begin
                rast_xi   = tri_field(hold, X2_OFF);
                rast_yi   = tri_field(hold, Y2_OFF);
                state_nxt = rast_busy ? RUN : WAIT;
            end
            WAIT: begin
                if (rast_busy) begin
                    state_nxt = RUN;
                end else if (tmo_cnt == TMO_W'(START_TMO - 1)) begin
                    tmo_fire  = 1'b1;
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (!rast_busy) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // done is registered alongside the pixel pipeline so that a final pixel
    // seen in the busy-falling cycle emerges together with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold      <= '0;
            owner     <= 1'b0;
            tmo_cnt   <= '0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_id    <= 1'b0;
            done      <= 1'b0;
            done_id   <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (|req_ready) begin
                hold  <= gnt[1] ? req_tri1 : req_tri0;
                owner <= gnt[1];
            end
            // Any non-WAIT state holds zero, so WAIT is always entered cleared
            tmo_cnt   <= (state == WAIT) ? tmo_cnt + 1'b1 : '0;
            pix_valid <= pix_take;
            pix_x     <= pix_take ? rast_xo : '0;
            pix_y     <= pix_take ? rast_yo : '0;
            pix_id    <= pix_take ? owner : 1'b0;
            done      <= finish;
            done_id   <= finish ? owner : 1'b0;
            err       <= err | tmo_fire;
        end
    end

endmodule

// File: tb/tb_tri_dispatch.sv
// Self-checking bench for tri_dispatch: directed scenarios plus randomized
// submissions, checked against a transaction-level model of arbitration,
// vertex streaming, pixel forwarding, completion and timeout.
module tb_tri_dispatch;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [17:0] req_tri0, req_tri1;
    logic [1:0]  req_ready;
    logic        rast_nt;
    logic [2:0]  rast_xi, rast_yi;
    logic        rast_busy, rast_po;
    logic [2:0]  rast_xo, rast_yo;
    logic        pix_valid;
    logic [2:0]  pix_x, pix_y;
    logic        pix_id, done, done_id, err, busy;

    int passes = 0;
    int total  = 0;
    int fails  = 0;

    // Model state
    int prio      = 0;
    bit err_m     = 1'b0;
    int pix_sent  = 0;
    int pix_got   = 0;

    tri_dispatch #(.START_TMO(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_tri0  (req_tri0),
        .req_tri1  (req_tri1),
        .req_ready (req_ready),
        .rast_nt   (rast_nt),
        .rast_xi   (rast_xi),
        .rast_yi   (rast_yi),
        .rast_busy (rast_busy),
        .rast_po   (rast_po),
        .rast_xo   (rast_xo),
        .rast_yo   (rast_yo),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_id    (pix_id),
        .done      (done),
        .done_id   (done_id),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rast_nt"},   rast_nt,   0);
        chk({tag, "_rast_xi"},   rast_xi,   0);
        chk({tag, "_rast_yi"},   rast_yi,   0);
        chk({tag, "_pix_valid"}, pix_valid, 0);
        chk({tag, "_pix_x"},     pix_x,     0);
        chk({tag, "_pix_y"},     pix_y,     0);
        chk({tag, "_pix_id"},    pix_id,    0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_done_id"},   done_id,   0);
        chk({tag, "_err"},       err,       0);
        chk({tag, "_busy"},      busy,      0);
    endtask

    // One triangle transaction, entered during an IDLE cycle (after negedge).
    // Rasterizer is held idle for wait_len cycles starting at LOAD2, then busy
    // for busy_len cycles, then drops; with tmo it never rises.
    task automatic submit(input logic [1:0] rv, input int wait_len, input int busy_len,
                          input bit tmo, input bit last_po, input int rst_at,
                          input bit fixed, input logic [17:0] tfix);
        int g, end_k;
        logic [17:0] t0, t1, tg;
        bit prev_act, prev_po;
        logic [2:0] prev_x, prev_y;

        g    = (rv == 2'b11) ? prio : (rv[1] ? 1 : 0);
        prio = 1 - g;
        t0   = fixed ? tfix : 18'($urandom);
        t1   = fixed ? tfix : 18'($urandom);
        tg   = (g == 1) ? t1 : t0;
        req_tri0  = t0;
        req_tri1  = t1;
        req_valid = rv;
        rast_busy = 1'b0;
        rast_po   = 1'($urandom);   // stray pixel in IDLE, must be ignored
        rast_xo   = 3'($urandom);
        rast_yo   = 3'($urandom);
        #1;
        chk("grant", req_ready, 32'(1 << g));
        chk("idle_busy", busy, 0);

        @(negedge clk);  // LOAD0
        chk("load0_nt", rast_nt, 1);
        chk("load0_x", rast_xi, tg[2:0]);
        chk("load0_y", rast_yi, tg[5:3]);
        chk("load0_ready", req_ready, 0);
        chk("load0_busy", busy, 1);
        chk("stray_po_idle", pix_valid, 0);
        chk("done_once", done, 0);
        chk("err_hold", err, err_m);
        // Inputs wander while loading; captured triangle must not change
        req_valid = 2'($urandom);
        req_tri0  = 18'($urandom);
        req_tri1  = 18'($urandom);
        rast_po   = 1'($urandom);

        @(negedge clk);  // LOAD1
        chk("load1_nt", rast_nt, 0);
        chk("load1_x", rast_xi, tg[8:6]);
        chk("load1_y", rast_yi, tg[11:9]);
        chk("po_load0", pix_valid, 0);
        rast_po = 1'($urandom);

        @(negedge clk);  // LOAD2
        chk("load2_x", rast_xi, tg[14:12]);
        chk("load2_y", rast_yi, tg[17:15]);
        chk("po_load1", pix_valid, 0);
        end_k     = tmo ? TMO : wait_len + busy_len;
        rast_busy = !tmo && (wait_len == 0);
        rast_po   = 1'($urandom);
        if (tmo) err_m = 1'b1;
        prev_act = 1'b0;
        prev_po  = 1'b0;
        prev_x   = '0;
        prev_y   = '0;

        for (int k = 1; k <= end_k + 1; k++) begin
            @(negedge clk);
            if (pix_valid) pix_got++;
            chk("pix_valid", pix_valid, prev_act && prev_po);
            if (prev_act && prev_po) begin
                chk("pix_x", pix_x, prev_x);
                chk("pix_y", pix_y, prev_y);
                chk("pix_id", pix_id, g);
            end
            chk("nt_off", rast_nt, 0);
            chk("xi_off", rast_xi, 0);
            if (k == end_k + 1) begin
                chk("done", done, 1);
                chk("done_id", done_id, g);
                chk("err", err, err_m);
                chk("busy_end", busy, 0);
                rast_busy = 1'b0;
                rast_po   = 1'b0;
                req_valid = 2'b00;
            end else begin
                chk("done_early", done, 0);
                chk("busy_mid", busy, 1);
                if (k == rst_at) begin
                    reset     = 1'b1;
                    req_valid = 2'b00;
                    rast_po   = 1'b1;
                    @(negedge clk);
                    chk_zero("rst_run");
                    reset     = 1'b0;
                    rast_busy = 1'b0;
                    rast_po   = 1'b0;
                    @(negedge clk);
                    chk("rst_no_done", done, 0);
                    chk("rst_idle", busy, 0);
                    chk("rst_no_pix", pix_valid, 0);
                    prio  = 0;
                    err_m = 1'b0;
                    return;
                end
                rast_busy = !tmo && (k >= wait_len) && (k < end_k);
                rast_po   = (last_po && k == end_k) ? 1'b1 : 1'($urandom);
                rast_xo   = 3'($urandom);
                rast_yo   = 3'($urandom);
                if (rast_po) pix_sent++;
                prev_po = rast_po;
                prev_x  = rast_xo;
                prev_y  = rast_yo;
            end
            prev_act = 1'b1;
        end
        chk("pix_count", pix_got, pix_sent);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 2'b00;
        req_tri0  = '0;
        req_tri1  = '0;
        rast_busy = 1'b0;
        rast_po   = 1'b1;
        rast_xo   = 3'd5;
        rast_yo   = 3'd6;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_zero("reset");

        // Stray pixel in IDLE
        rast_po = 1'b1;
        @(negedge clk);
        chk("stray_po", pix_valid, 0);
        chk("stray_busy", busy, 0);
        rast_po = 1'b0;

        // Single submit, tri {0,0,0,3,3,0}: xi 0,3,0; last pixel overlaps busy fall
        submit(2'b01, 0, 4, 1'b0, 1'b1, -1, 1'b1, {3'd0, 3'd0, 3'd0, 3'd3, 3'd3, 3'd0});

        // Start timeout
        submit(2'b10, 0, 0, 1'b1, 1'b0, -1, 1'b0, '0);
        chk("err_sticky", err, 1);

        // Reset mid-RUN (WAIT k=1..2, RUN from k=3)
        submit(2'b10, 2, 5, 1'b0, 1'b0, 4, 1'b0, '0);

        // Contention from fresh priority: grants 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            submit(2'b11, i % 3, 2 + i, 1'b0, 1'b1, -1, 1'b0, '0);
        end

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            submit(2'($urandom_range(1, 3)), $urandom_range(0, 3), $urandom_range(1, 6),
                   ($urandom_range(0, 7) == 0), 1'($urandom), -1, 1'b0, '0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
